parking_gate_ctrl: RTL and testbench

Sequencing controller for the single-lane barrier gate of the parking lot. It latches entry and exit requests from the vehicle-detection FSMs and arbitrates the shared gate between them, alternating direction under contention. It drives the gate open and closed and owns the occupancy counter. It sits between the debounce/edge-detect/FSM front end and the 7-segment count display.

---
 rtl/parking_gate_ctrl.sv | 161 ++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Barrier-gate sequencer: latches entry/exit requests, arbitrates the single lane,
// times the open window and owns the occupancy counter.
module parking_gate_ctrl #(
    parameter int CAPACITY = 7,
    parameter int CNT_W    = 3,
    parameter int TIMEOUT  = 200,
    parameter int TMR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             car_passed,
    input  logic             gate_closed,
    output logic             gate_open,
    output logic             dir_in,
    output logic             grant_in,
    output logic             grant_out,
    output logic             reject_in,
    output logic             reject_out,
    output logic             timeout_err,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    // state | meaning
    // IDLE  | gate down, arbitrating pending requests
    // OPEN  | gate raised for the granted direction, open-time timer running
    // CLOSE | gate commanded down, waiting for the closed limit switch
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CAP_VAL  = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             pend_in, pend_in_nxt;
    logic             pend_out, pend_out_nxt;
    logic             last_dir, last_dir_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             dir_in_nxt;
    logic             grant_in_nxt, grant_out_nxt;
    logic             reject_in_nxt, reject_out_nxt;
    logic             timeout_nxt;
    logic             clr_in, clr_out;
    logic             in_ok, out_ok, pick_in, pick_out;

    assign full  = (count == CAP_VAL);
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pend_in     <= 1'b0;
            pend_out    <= 1'b0;
            last_dir    <= 1'b0;
            timer       <= '0;
            count       <= '0;
            gate_open   <= 1'b0;
            dir_in      <= 1'b1;
            grant_in    <= 1'b0;
            grant_out   <= 1'b0;
            reject_in   <= 1'b0;
            reject_out  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_in     <= pend_in_nxt;
            pend_out    <= pend_out_nxt;
            last_dir    <= last_dir_nxt;
            timer       <= timer_nxt;
            count       <= count_nxt;
            gate_open   <= (state_nxt == OPEN);
            dir_in      <= dir_in_nxt;
            grant_in    <= grant_in_nxt;
            grant_out   <= grant_out_nxt;
            reject_in   <= reject_in_nxt;
            reject_out  <= reject_out_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    // Only the registered flags are eligible; a request arriving this edge waits one cycle.
    assign in_ok    = pend_in && !full;
    assign out_ok   = pend_out && !empty;
    assign pick_in  = in_ok && (!out_ok || !last_dir);
    assign pick_out = out_ok && !pick_in;

    always_comb begin
        state_nxt      = state;
        last_dir_nxt   = last_dir;
        timer_nxt      = timer;
        count_nxt      = count;
        dir_in_nxt     = dir_in;
        grant_in_nxt   = 1'b0;
        grant_out_nxt  = 1'b0;
        reject_in_nxt  = 1'b0;
        reject_out_nxt = 1'b0;
        timeout_nxt    = 1'b0;
        clr_in         = 1'b0;
        clr_out        = 1'b0;

        case (state)
            IDLE: begin
                if (pend_in && full) begin
                    reject_in_nxt = 1'b1;
                    clr_in        = 1'b1;
                end
                if (pend_out && empty) begin
                    reject_out_nxt = 1'b1;
                    clr_out        = 1'b1;
                end
                if (pick_in) begin
                    state_nxt    = OPEN;
                    dir_in_nxt   = 1'b1;
                    last_dir_nxt = 1'b1;
                    grant_in_nxt = 1'b1;
                    clr_in       = 1'b1;
                    timer_nxt    = '0;
                end else if (pick_out) begin
                    state_nxt     = OPEN;
                    dir_in_nxt    = 1'b0;
                    last_dir_nxt  = 1'b0;
                    grant_out_nxt = 1'b1;
                    clr_out       = 1'b1;
                    timer_nxt     = '0;
                end
            end
            OPEN: begin
                // A passage on the timeout edge still counts and suppresses the error.
                if (car_passed) begin
                    count_nxt = dir_in ? count + CNT_W'(1) : count - CNT_W'(1);
                    state_nxt = CLOSE;
                end else if (timer == TMR_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = CLOSE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            CLOSE: begin
                if (gate_closed) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // New request outranks the clear so it stays queued.
        pend_in_nxt  = entry_req || (pend_in && !clr_in);
        pend_out_nxt = exit_req || (pend_out && !clr_out);
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: grant latency, arbitration, bounds,
// timeout and asynchronous reset, all with hand-computed expectations.
module tb_parking_gate_ctrl;

    localparam int CAPACITY = 7;
    localparam int CNT_W    = 3;
    localparam int TIMEOUT  = 200;
    localparam int TMR_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             entry_req = 1'b0;
    logic             exit_req = 1'b0;
    logic             car_passed = 1'b0;
    logic             gate_closed = 1'b1;
    logic             gate_open;
    logic             dir_in;
    logic             grant_in;
    logic             grant_out;
    logic             reject_in;
    logic             reject_out;
    logic             timeout_err;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    int total = 0;
    int bad   = 0;

    parking_gate_ctrl #(
        .CAPACITY(CAPACITY),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .car_passed (car_passed),
        .gate_closed(gate_closed),
        .gate_open  (gate_open),
        .dir_in     (dir_in),
        .grant_in   (grant_in),
        .grant_out  (grant_out),
        .reject_in  (reject_in),
        .reject_out (reject_out),
        .timeout_err(timeout_err),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full uncontended passage in one direction, returning to IDLE with the gate closed.
    task automatic pass_car(input logic is_entry);
        entry_req = is_entry;
        exit_req  = !is_entry;
        tick();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        chk("rst_gate_open", gate_open, 0);
        chk("rst_dir_in", dir_in, 1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pulses", {grant_in, grant_out, reject_in, reject_out, timeout_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: entry latency and passage
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        chk("t1_no_grant_yet", {grant_in, gate_open}, 0);
        tick();
        chk("t1_grant_in", grant_in, 1);
        chk("t1_gate_open", gate_open, 1);
        chk("t1_dir_in", dir_in, 1);
        tick();
        chk("t1_grant_pulse_end", grant_in, 0);
        chk("t1_still_open", gate_open, 1);
        tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        chk("t1_count", count, 1);
        chk("t1_gate_closed_cmd", gate_open, 0);
        // CLOSE holds while the barrier is still moving; a request is latched meanwhile.
        gate_closed = 1'b0;
        exit_req    = 1'b1;
        tick();
        exit_req = 1'b0;
        tick();
        chk("t1_close_wait", {gate_open, grant_out}, 0);
        gate_closed = 1'b1;
        tick();
        tick();
        chk("t1_queued_exit_grant", grant_out, 1);
        chk("t1_queued_exit_dir", dir_in, 0);
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        chk("t1_count_after_exit", count, 0);
        tick();

        // car_passed outside OPEN is ignored
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        chk("idle_car_passed_ignored", count, 0);

        // 2: contention, last_dir=exit -> entry first
        for (int i = 0; i < 3; i++) pass_car(1'b1);
        pass_car(1'b0);
        pass_car(1'b1);
        chk("t2_count_pre", count, 3);
        pass_car(1'b0);
        pass_car(1'b0);
        pass_car(1'b1);
        pass_car(1'b1);
        pass_car(1'b0);
        pass_car(1'b1);
        // count=3, last grant was entry; redo so last_dir=exit
        pass_car(1'b0);
        pass_car(1'b1);
        pass_car(1'b0);
        chk("t2_count_setup", count, 2);
        pass_car(1'b1);
        pass_car(1'b0);
        pass_car(1'b1);
        pass_car(1'b0);
        pass_car(1'b1);
        chk("t2_count3", count, 3);
        pass_car(1'b0);
        pass_car(1'b1);
        // last grant = entry here; swap once more to leave last_dir=exit at count 3
        pass_car(1'b1);
        pass_car(1'b0);
        chk("t2_count3_lastexit", count, 3);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        tick();
        chk("t2_tie_grant_in", {grant_in, grant_out}, 2'b10);
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        chk("t2_count4", count, 4);
        tick();
        tick();
        chk("t2_then_grant_out", {grant_in, grant_out}, 2'b01);
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        tick();
        chk("t2_final_count", count, 3);

        // tie with last_dir=exit again: one entry passage makes last_dir=entry -> exit wins
        pass_car(1'b1);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        tick();
        chk("t2b_tie_grant_out", {grant_in, grant_out}, 2'b01);
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        tick();
        tick();
        chk("t2b_then_grant_in", {grant_in, grant_out}, 2'b10);
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        tick();
        chk("t2b_count", count, 4);

        // 3: fill to capacity, then refuse
        for (int i = 0; i < 3; i++) pass_car(1'b1);
        chk("t3_count7", count, 7);
        chk("t3_full", full, 1);
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        tick();
        chk("t3_reject_in", reject_in, 1);
        chk("t3_no_gate", {gate_open, grant_in}, 0);
        chk("t3_count_held", count, 7);
        tick();
        chk("t3_reject_pulse_end", reject_in, 0);

        // both rejects cannot coincide here (full), but reject_in with grant_out can
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        tick();
        chk("t3_reject_and_grant", {reject_in, grant_out, gate_open}, 3'b111);
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        tick();
        chk("t3_count6", count, 6);

        // 4: exit on empty lot
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        tick();
        chk("t4_reject_out", reject_out, 1);
        chk("t4_no_gate", {gate_open, grant_out}, 0);
        chk("t4_count", count, 0);
        chk("t4_empty", empty, 1);

        // 5: timeout exactly TIMEOUT cycles after entering OPEN
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        tick();
        chk("t5_grant", grant_in, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("t5_before_timeout", {timeout_err, gate_open}, 2'b01);
        tick();
        chk("t5_timeout_err", timeout_err, 1);
        chk("t5_gate_open", gate_open, 0);
        chk("t5_count", count, 0);
        tick();
        chk("t5_pulse_end", timeout_err, 0);

        // passage on the timeout edge wins
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        car_passed = 1'b1;
        tick();
        car_passed = 1'b0;
        chk("t5b_no_timeout", timeout_err, 0);
        chk("t5b_count", count, 1);
        tick();

        // 6: reset mid-OPEN, pending requests forgotten
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        tick();
        chk("t6_open", gate_open, 1);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick();
        entry_req = 1'b0;
        exit_req  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_gate", gate_open, 0);
        chk("t6_async_count", count, 0);
        chk("t6_async_dir", dir_in, 1);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_no_memory", {grant_in, grant_out, reject_out, gate_open}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
